// File: rtl/mem_drain_unit_pkg.sv
// Types shared between the memory queue and the memory drain unit.
package mem_drain_unit_pkg;

    localparam int MD_DATA_W = 16;
    localparam int MD_ADDR_W = 16;
    localparam int NUM_D_REG = 16;
    localparam int D_REG_W   = $clog2(NUM_D_REG);

    // One queued memory operation as it leaves the head of the memory queue.
    typedef struct packed {
        logic                 is_store;
        logic [MD_DATA_W-1:0] data;
        logic [MD_ADDR_W-1:0] mem_addr;
        logic [D_REG_W-1:0]   reg_addr;
    } mq_entry_t;

endpackage

// File: rtl/mem_drain_timer.sv
// Saturating response timer: cleared when a load is accepted, advanced while
// waiting for read data, flags the last permitted wait cycle.
module mem_drain_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam int            CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear wins, increment stops at all-ones so it never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == CNT_TC);

endmodule

// File: rtl/mem_drain_unit.sv
// Drains the memory queue one operation at a time onto the data-memory port
// and writes load results back to the data register file.
module mem_drain_unit
    import mem_drain_unit_pkg::*;
#(
    parameter int DATA_W  = MD_DATA_W,  // must equal the queue entry data width
    parameter int ADDR_W  = MD_ADDR_W,  // must equal the queue entry address width
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mq_valid,
    input  mq_entry_t          mq_entry,
    output logic               mq_pop,
    input  logic               flush,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [ADDR_W-1:0]  dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic               dmem_ready,
    input  logic               dmem_rvalid,
    input  logic [DATA_W-1:0]  dmem_rdata,
    output logic               wb_valid,
    output logic [D_REG_W-1:0] wb_reg,
    output logic [DATA_W-1:0]  wb_data,
    output logic               store_done,
    output logic               busy,
    output logic               timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_RD,
        S_WB,
        S_DISCARD
    } state_e;

    state_e    state_q, state_d;
    mq_entry_t hold_q, hold_d;
    logic      timeout_err_q, timeout_err_d;
    logic      tmr_clr, tmr_inc, tmr_tc;

    mem_drain_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (tmr_clr),
        .inc (tmr_inc),
        .tc  (tmr_tc)
    );

    // Next state, holding register update and all decoded outputs.
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        timeout_err_d = timeout_err_q;
        tmr_clr       = 1'b0;
        tmr_inc       = 1'b0;
        mq_pop        = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        dmem_addr     = '0;
        dmem_wdata    = '0;
        wb_valid      = 1'b0;
        wb_reg        = '0;
        wb_data       = '0;
        store_done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A load facing a flush is left for the queue's own squash.
                mq_pop = ~rst & mq_valid & ~(flush & ~mq_entry.is_store);
                if (mq_pop) begin
                    hold_d  = mq_entry;
                    state_d = S_REQ;
                end
            end

            S_REQ: begin
                dmem_we    = hold_q.is_store;
                dmem_addr  = hold_q.mem_addr;
                dmem_wdata = hold_q.data;
                if (hold_q.is_store) begin
                    // Stores are committed and ignore flush.
                    dmem_req = 1'b1;
                    if (dmem_ready) begin
                        store_done = 1'b1;
                        state_d    = S_IDLE;
                    end
                end else if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    dmem_req = 1'b1;
                    if (dmem_ready) begin
                        tmr_clr = 1'b1;
                        state_d = S_WAIT_RD;
                    end
                end
            end

            S_WAIT_RD: begin
                // Flush beats a simultaneous rvalid: the data is squashed.
                if (flush) begin
                    state_d = S_DISCARD;
                end else if (dmem_rvalid) begin
                    hold_d.data = dmem_rdata;
                    state_d     = S_WB;
                end else if (tmr_tc) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    tmr_inc = 1'b1;
                end
            end

            S_WB: begin
                wb_valid = ~flush;
                wb_reg   = hold_q.reg_addr;
                wb_data  = hold_q.data;
                state_d  = S_IDLE;
            end

            S_DISCARD: begin
                // Still owed one response; swallow it before issuing again.
                if (dmem_rvalid) begin
                    state_d = S_IDLE;
                end else if (tmr_tc) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    tmr_inc = 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State, holding register and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            hold_q        <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_drain_unit.sv
// Directed scenarios followed by a randomized drain checked against a
// transaction-level scoreboard of requests and writebacks.
module tb_mem_drain_unit;
    import mem_drain_unit_pkg::*;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 16;
    localparam int TIMEOUT = 8;
    localparam int N_OPS   = 40;

    logic               clk = 1'b0;
    logic               rst;
    logic               mq_valid;
    mq_entry_t          mq_entry;
    logic               mq_pop;
    logic               flush;
    logic               dmem_req;
    logic               dmem_we;
    logic [ADDR_W-1:0]  dmem_addr;
    logic [DATA_W-1:0]  dmem_wdata;
    logic               dmem_ready;
    logic               dmem_rvalid;
    logic [DATA_W-1:0]  dmem_rdata;
    logic               wb_valid;
    logic [D_REG_W-1:0] wb_reg;
    logic [DATA_W-1:0]  wb_data;
    logic               store_done;
    logic               busy;
    logic               timeout_err;

    int n_cmp = 0;
    int n_bad = 0;

    mem_drain_unit #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mq_valid    (mq_valid),
        .mq_entry    (mq_entry),
        .mq_pop      (mq_pop),
        .flush       (flush),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_ready  (dmem_ready),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata),
        .wb_valid    (wb_valid),
        .wb_reg      (wb_reg),
        .wb_data     (wb_data),
        .store_done  (store_done),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the rising edge, outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    function automatic mq_entry_t mk(input logic st, input logic [15:0] d,
                                     input logic [15:0] a, input logic [D_REG_W-1:0] r);
        mq_entry_t e;
        e.is_store = st;
        e.data     = d;
        e.mem_addr = a;
        e.reg_addr = r;
        return e;
    endfunction

    mq_entry_t          ops [N_OPS];
    mq_entry_t          exp_req [$];
    logic [D_REG_W-1:0] exp_wb_reg [$];
    logic [DATA_W-1:0]  exp_wb_dat [$];

    initial begin
        int                 idx;
        int                 cd;
        int                 budget;
        logic [D_REG_W-1:0] pend_reg;

        rst = 1'b1; flush = 1'b0; dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        mq_valid = 1'b1; mq_entry = mk(1'b1, 16'h1111, 16'h0010, 4'd1);

        // Reset state, with a valid head that must not be popped.
        sample();
        check("rst_mq_pop", mq_pop, 0);
        check("rst_busy", busy, 0);
        check("rst_dmem_req", dmem_req, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_store_done", store_done, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_dmem_addr", dmem_addr, 0);
        mq_valid = 1'b0;
        @(posedge clk); #3; rst = 1'b0;

        // Store: request in cycle 1 with store_done.
        step(); mq_valid = 1'b1; mq_entry = mk(1'b1, 16'hBEEF, 16'h0040, 4'd0); dmem_ready = 1'b1;
        sample(); check("st_pop", mq_pop, 1); check("st_idle_req", dmem_req, 0);
        step(); mq_valid = 1'b0;
        sample();
        check("st_req", dmem_req, 1); check("st_we", dmem_we, 1);
        check("st_addr", dmem_addr, 16'h0040); check("st_wdata", dmem_wdata, 16'hBEEF);
        check("st_done", store_done, 1); check("st_pop_once", mq_pop, 0);
        step(); dmem_ready = 1'b0;
        sample(); check("st_after_busy", busy, 0); check("st_after_done", store_done, 0);

        // Load with 4 cycles of backpressure, data two cycles after acceptance.
        step(); mq_valid = 1'b1; mq_entry = mk(1'b0, 16'h0000, 16'h0100, 4'd3);
        sample(); check("ld_pop", mq_pop, 1);
        for (int i = 0; i < 4; i++) begin
            step(); mq_valid = 1'b0; dmem_ready = 1'b0;
            sample(); check("ld_bp_req", dmem_req, 1); check("ld_bp_we", dmem_we, 0);
            check("ld_bp_addr", dmem_addr, 16'h0100);
        end
        step(); dmem_ready = 1'b1;
        sample(); check("ld_acc_req", dmem_req, 1); check("ld_acc_addr", dmem_addr, 16'h0100);
        step(); dmem_ready = 1'b0;
        sample(); check("ld_wait_req", dmem_req, 0); check("ld_wait_wb", wb_valid, 0);
        step(); dmem_rvalid = 1'b1; dmem_rdata = 16'h1234;
        sample(); check("ld_rv_wb", wb_valid, 0); check("ld_rv_busy", busy, 1);
        step(); dmem_rvalid = 1'b0; dmem_rdata = 16'h0000;
        sample(); check("ld_wb_valid", wb_valid, 1); check("ld_wb_reg", wb_reg, 3);
        check("ld_wb_data", wb_data, 16'h1234);
        step();
        sample(); check("ld_wb_once", wb_valid, 0); check("ld_idle", busy, 0);

        // Flush during WAIT_RD: response dropped, next pop after rvalid.
        step(); mq_valid = 1'b1; mq_entry = mk(1'b0, 16'h0000, 16'h0200, 4'd5);
        sample(); check("fl_pop", mq_pop, 1);
        step(); mq_valid = 1'b0; dmem_ready = 1'b1;
        sample(); check("fl_req", dmem_req, 1);
        step(); dmem_ready = 1'b0; flush = 1'b1;
        sample(); check("fl_wait_wb", wb_valid, 0);
        step(); flush = 1'b0;
        sample(); check("fl_disc_busy", busy, 1); check("fl_disc_req", dmem_req, 0);
        step(); dmem_rvalid = 1'b1; dmem_rdata = 16'hAAAA;
        mq_valid = 1'b1; mq_entry = mk(1'b1, 16'h5555, 16'h0300, 4'd0);
        sample(); check("fl_rv_pop", mq_pop, 0); check("fl_rv_wb", wb_valid, 0);
        step(); dmem_rvalid = 1'b0;
        sample(); check("fl_next_pop", mq_pop, 1); check("fl_no_wb", wb_valid, 0);
        step(); mq_valid = 1'b0; dmem_ready = 1'b1;
        sample(); check("fl_st_addr", dmem_addr, 16'h0300); check("fl_st_done", store_done, 1);
        step(); dmem_ready = 1'b0;
        sample(); check("fl_st_idle", busy, 0);

        // A load at the head under flush is not taken.
        step(); mq_valid = 1'b1; mq_entry = mk(1'b0, 16'h0000, 16'h0070, 4'd2); flush = 1'b1;
        sample(); check("fi_pop", mq_pop, 0);
        step(); mq_valid = 1'b0; flush = 1'b0;
        sample(); check("fi_busy", busy, 0); check("fi_req", dmem_req, 0);

        // Flush against a load in REQ: the request is dropped.
        step(); mq_valid = 1'b1; flush = 1'b0;
        sample(); check("fr_pop", mq_pop, 1);
        step(); mq_valid = 1'b0; flush = 1'b1; dmem_ready = 1'b1;
        sample(); check("fr_req", dmem_req, 0);
        step(); flush = 1'b0; dmem_ready = 1'b0;
        sample(); check("fr_idle", busy, 0);

        // Timeout: no response, error after TIMEOUT cycles, then a normal store.
        step(); mq_valid = 1'b1; mq_entry = mk(1'b0, 16'h0000, 16'h0500, 4'd6);
        sample(); check("to_pop", mq_pop, 1);
        step(); mq_valid = 1'b0; dmem_ready = 1'b1;
        sample(); check("to_req", dmem_req, 1);
        for (int k = 1; k <= TIMEOUT; k++) begin
            step(); dmem_ready = 1'b0;
            sample(); check("to_wait_err", timeout_err, 0); check("to_wait_busy", busy, 1);
        end
        step();
        sample(); check("to_err", timeout_err, 1); check("to_idle", busy, 0);
        step(); mq_valid = 1'b1; mq_entry = mk(1'b1, 16'h0F0F, 16'h0050, 4'd0); dmem_ready = 1'b1;
        sample(); check("to_st_pop", mq_pop, 1);
        step(); mq_valid = 1'b0;
        sample(); check("to_st_done", store_done, 1); check("to_st_wdata", dmem_wdata, 16'h0F0F);
        check("to_err_sticky", timeout_err, 1);
        step(); dmem_ready = 1'b0;
        sample(); check("to_err_sticky2", timeout_err, 1);

        // Flush against a store in REQ: store still issued.
        step(); mq_valid = 1'b1; mq_entry = mk(1'b1, 16'hCAFE, 16'h0060, 4'd0);
        sample(); check("fs_pop", mq_pop, 1);
        for (int i = 0; i < 2; i++) begin
            step(); mq_valid = 1'b0; flush = 1'b1; dmem_ready = 1'b0;
            sample(); check("fs_req", dmem_req, 1); check("fs_we", dmem_we, 1);
            check("fs_done_early", store_done, 0);
        end
        step(); dmem_ready = 1'b1;
        sample(); check("fs_done", store_done, 1); check("fs_addr", dmem_addr, 16'h0060);
        check("fs_wdata", dmem_wdata, 16'hCAFE);
        step(); flush = 1'b0; dmem_ready = 1'b0;
        sample(); check("fs_idle", busy, 0);

        // Asynchronous reset in WAIT_RD, then a late response.
        step(); mq_valid = 1'b1; mq_entry = mk(1'b0, 16'h0000, 16'h0080, 4'd7);
        sample(); check("ar_pop", mq_pop, 1);
        step(); mq_valid = 1'b0; dmem_ready = 1'b1;
        sample(); check("ar_req", dmem_req, 1);
        step(); dmem_ready = 1'b0;
        sample(); check("ar_busy_pre", busy, 1); check("ar_err_pre", timeout_err, 1);
        #2; rst = 1'b1;
        #1;
        check("ar_busy", busy, 0); check("ar_req0", dmem_req, 0);
        check("ar_wb", wb_valid, 0); check("ar_err", timeout_err, 0);
        @(posedge clk); #2; rst = 1'b0;
        step(); dmem_rvalid = 1'b1; dmem_rdata = 16'h9999;
        sample(); check("ar_late_wb", wb_valid, 0); check("ar_late_busy", busy, 0);
        step(); dmem_rvalid = 1'b0;
        sample(); check("ar_late_wb2", wb_valid, 0);

        // Randomized drain against a request/writeback scoreboard.
        for (int i = 0; i < N_OPS; i++) begin
            ops[i] = mk(1'($urandom), 16'($urandom), 16'($urandom), D_REG_W'($urandom));
        end
        idx = 0; cd = 0; budget = 0; pend_reg = '0;
        while ((idx < N_OPS || exp_req.size() != 0 || cd != 0 || exp_wb_reg.size() != 0)
               && budget < 3000) begin
            budget++;
            step();
            mq_valid    = (idx < N_OPS) && ($urandom_range(0, 3) != 0);
            mq_entry    = (idx < N_OPS) ? ops[idx] : '0;
            dmem_ready  = ($urandom_range(0, 2) != 0);
            dmem_rdata  = 16'($urandom);
            dmem_rvalid = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) dmem_rvalid = 1'b1;
            end
            sample();
            if (mq_pop) begin
                check("rnd_pop_valid", mq_valid, 1);
                exp_req.push_back(mq_entry);
                idx++;
            end
            if (dmem_req) begin
                if (exp_req.size() == 0) begin
                    check("rnd_req_unexpected", dmem_req, 0);
                end else begin
                    check("rnd_we", dmem_we, exp_req[0].is_store);
                    check("rnd_addr", dmem_addr, exp_req[0].mem_addr);
                    if (exp_req[0].is_store) check("rnd_wdata", dmem_wdata, exp_req[0].data);
                    check("rnd_store_done", store_done, exp_req[0].is_store & dmem_ready);
                    if (dmem_ready) begin
                        if (!exp_req[0].is_store) begin
                            cd       = $urandom_range(1, 3);
                            pend_reg = exp_req[0].reg_addr;
                        end
                        void'(exp_req.pop_front());
                    end
                end
            end
            if (wb_valid) begin
                if (exp_wb_reg.size() == 0) begin
                    check("rnd_wb_unexpected", wb_valid, 0);
                end else begin
                    check("rnd_wb_reg", wb_reg, exp_wb_reg.pop_front());
                    check("rnd_wb_data", wb_data, exp_wb_dat.pop_front());
                end
            end
            if (dmem_rvalid) begin
                exp_wb_reg.push_back(pend_reg);
                exp_wb_dat.push_back(dmem_rdata);
            end
        end
        check("rnd_drained", (idx == N_OPS) && (exp_req.size() == 0) && (exp_wb_reg.size() == 0), 1);
        check("rnd_no_timeout", timeout_err, 0);
        step(); mq_valid = 1'b0; dmem_ready = 1'b0; dmem_rvalid = 1'b0;
        sample(); check("rnd_end_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
